// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex driver for DIGITS seven-segment digits on a shared segment bus.
// New values are double-buffered and take effect only at a frame boundary.
module seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0]        SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic              SEGDP_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF    = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic                lz;
  } disp_t;

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  disp_t             pend;
  disp_t             act;
  disp_t             in_buf;
  logic              pend_valid;
  logic              wrap;
  logic              frame_end;
  logic [DIGITS-1:0] supp;
  logic              zero_above;
  logic [3:0]        cur_nib;
  logic              cur_lit;
  logic              cur_dp;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      default: glyph = 7'b1110001;
    endcase
  endfunction

  always_comb begin
    in_buf    = {value, dp, blank, lz_en};
    wrap      = (cnt == CNT_LAST);
    frame_end = wrap && (idx == IDX_LAST);
  end

  // Suppression walks down from the top digit; digit 0 is never suppressed.
  always_comb begin
    supp       = '0;
    zero_above = 1'b1;
    for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
      zero_above             = zero_above & (act.value[4*(DIGITS-1-k) +: 4] == 4'h0);
      supp[DIGITS-1-k]       = act.lz & zero_above;
    end
  end

  always_comb begin
    cur_nib = '0;
    cur_lit = 1'b0;
    cur_dp  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = act.value[4*i +: 4];
        cur_lit = ~act.blank[i] & ~supp[i];
        cur_dp  = act.dp[i] & ~act.blank[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      pend        <= '0;
      act         <= '0;
      pend_valid  <= 1'b0;
      seg         <= SEG_OFF;
      seg_dp      <= SEGDP_OFF;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      if (load) pend <= in_buf;
      // A load on the boundary cycle bypasses the pending buffer so it is not lost.
      if (frame_end && (pend_valid || load)) begin
        act        <= load ? in_buf : pend;
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_valid <= 1'b1;
      end

      frame_start <= (cnt == '0) && (idx == '0);
      if (cnt < CNT_BLANK) begin
        an     <= AN_OFF;
        seg    <= SEG_OFF;
        seg_dp <= SEGDP_OFF;
      end else begin
        an     <= AN_OFF ^ (DIGITS'(1) << idx);
        seg    <= cur_lit ? (glyph(cur_nib) ^ SEG_OFF) : SEG_OFF;
        seg_dp <= cur_dp ^ SEGDP_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 8-cycle slots, 2 blank cycles, active-low outputs.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic        load;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic        frame_start;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int          j;
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
  } load_t;

  load_t loads[$];

  seg_scan_driver #(
    .DIGITS(4),
    .SCAN_DIV(8),
    .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .dp(dp),
    .blank(blank),
    .lz_en(lz_en),
    .load(load),
    .seg(seg),
    .seg_dp(seg_dp),
    .an(an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic sched(input int j, input logic [15:0] v, input logic [3:0] d,
                       input logic [3:0] b, input logic lz);
    load_t l;
    l.j = j; l.v = v; l.dp = d; l.blank = b; l.lz = lz;
    loads.push_back(l);
  endtask

  // exp_seg packs the active-low glyph per digit as {d3,d2,d1,d0}; exp_dpn is the lit-phase seg_dp.
  task automatic run_frame(input string name, input logic [27:0] exp_seg,
                           input logic [3:0] exp_dpn, input int nsteps);
    int c;
    int s;
    for (int j = 1; j <= nsteps; j++) begin
      load = 1'b0;
      if (loads.size() > 0 && loads[0].j == j) begin
        value = loads[0].v;
        dp    = loads[0].dp;
        blank = loads[0].blank;
        lz_en = loads[0].lz;
        load  = 1'b1;
        void'(loads.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
      c = (j - 1) % 8;
      s = (j - 1) / 8;
      check({name, "_fs"}, 32'(frame_start), 32'(j == 1));
      if (c < 2) begin
        check({name, "_an_blank"}, 32'(an), 32'h0000000F);
        check({name, "_seg_blank"}, 32'(seg), 32'h0000007F);
        check({name, "_dp_blank"}, 32'(seg_dp), 32'h00000001);
      end else begin
        check({name, "_an"}, 32'(an), 32'(4'(~(4'b0001 << s))));
        check({name, "_seg"}, 32'(seg), 32'(exp_seg[7*s +: 7]));
        check({name, "_dp"}, 32'(seg_dp), 32'(exp_dpn[s]));
      end
    end
    load = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    value = '0;
    dp    = '0;
    blank = '0;
    lz_en = 1'b0;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg", 32'(seg), 32'h0000007F);
    check("rst_dp", 32'(seg_dp), 32'h00000001);
    check("rst_fs", 32'(frame_start), 32'h00000000);
    rst = 1'b0;

    // Frame 0: reset contents; a mid-frame load must not show yet.
    sched(10, 16'h12AF, 4'b0000, 4'b0000, 1'b0);
    run_frame("f0", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 32);

    sched(3, 16'h0040, 4'b0000, 4'b0000, 1'b1);
    run_frame("f1_12AF", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111, 32);

    sched(3, 16'h0000, 4'b0000, 4'b0000, 1'b1);
    run_frame("f2_lz40", {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b1111, 32);

    // dp on digit 0 is requested but blanked, so it must stay dark.
    sched(3, 16'h0000, 4'b0101, 4'b0001, 1'b0);
    run_frame("f3_lz00", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, 32);

    sched(5, 16'h1111, 4'b0000, 4'b0000, 1'b0);
    sched(20, 16'h2222, 4'b0000, 4'b0000, 1'b0);
    sched(32, 16'h3333, 4'b0000, 4'b0000, 1'b0);
    run_frame("f4_dpblank", {7'h40, 7'h40, 7'h40, 7'h7F}, 4'b1011, 32);

    run_frame("f5_3333", {7'h30, 7'h30, 7'h30, 7'h30}, 4'b1111, 32);

    // Leave a pending load, then reset during digit 2's lit phase.
    sched(10, 16'h1111, 4'b1111, 4'b0000, 1'b0);
    run_frame("f6_part", {7'h30, 7'h30, 7'h30, 7'h30}, 4'b1111, 20);
    #2 rst = 1'b1;
    #1;
    check("arst_an", 32'(an), 32'h0000000F);
    check("arst_seg", 32'(seg), 32'h0000007F);
    check("arst_dp", 32'(seg_dp), 32'h00000001);
    check("arst_fs", 32'(frame_start), 32'h00000000);
    repeat (2) @(negedge clk);
    check("arst_hold_an", 32'(an), 32'h0000000F);
    rst = 1'b0;

    run_frame("f7_post", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 32);
    run_frame("f8_post", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 32);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised, time-multiplexed driver for N common-anode/cathode 7-segment digits sharing one segment bus.
- Scans digits round-robin and decodes each 4-bit nibble to hex glyphs 0-9, A, b, C, d, E, F.
- Adds decimal points, per-digit blanking, leading-zero suppression, anti-ghost blank time and tear-free frame-synchronous value update.
- Sits between the stopwatch counters and the board display pins.

Parameters:
- DIGITS, 4, number of digits; legal 1..8.
- SCAN_DIV, 50000, clock cycles per digit slot; must be > BLANK_CYCLES.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off (anti-ghost); legal 0..SCAN_DIV-1.
- SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs driven low when lit.
- AN_ACTIVE_LOW, 1, 1 = anode enable driven low when selected.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- value  in  4*DIGITS  nibble i = digit i; digit 0 is least significant/rightmost.
- dp  in  DIGITS  decimal point request per digit; sampled together with value.
- blank  in  DIGITS  1 = digit i dark; sampled together with value.
- lz_en  in  1  enable leading-zero suppression; sampled together with value.
- load  in  1  one-cycle strobe: capture value/dp/blank/lz_en into the pending buffer.
- seg  out  7  segments {g,f,e,d,c,b,a}; seg[0]=a.
- seg_dp  out  1  decimal-point segment.
- an  out  DIGITS  digit enables; an[i] selects digit i.
- frame_start  out  1  one-cycle pulse on the first cycle of each digit-0 slot.

Behaviour:
- Reset (async assert; sync release on next clk):
  - cnt=0, idx=0; pending and active buffers 0; pend_valid=0.
  - All outputs inactive: an all off, seg/seg_dp dark (polarity per parameters), frame_start=0.
- Scan counter:
  - cnt counts 0..SCAN_DIV-1, then wraps to 0 and idx advances.
  - idx wraps from DIGITS-1 to 0; frame period = DIGITS*SCAN_DIV cycles.
- Load:
  - On load=1, pending <= {value, dp, blank, lz_en} and pend_valid <= 1.
  - A later load before transfer overwrites pending (last wins).
- Frame-boundary transfer: on the cycle cnt wraps with idx=DIGITS-1, if pend_valid or load, active <= (load ? inputs : pending) and pend_valid <= 0. The display never mixes two loads within one frame.
- Glyph encoding, active-high, before polarity (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- Leading-zero suppression: with active lz_en=1, digit i (i>=1) is suppressed when its nibble and all higher nibbles are 0. Digit 0 is never suppressed.
- Visibility:
  - Digit lit = not blank[i] and not suppressed.
  - A dark digit outputs seg all-off. seg_dp still follows dp[i] unless blank[i]=1.
- Slot output, registered (one-cycle latency from cnt/idx):
  - While cnt < BLANK_CYCLES: an all off, seg/seg_dp off.
  - Otherwise: an[idx] on, others off, seg = glyph of active nibble idx.
  - Exactly one or zero anodes on in any cycle.
- frame_start is registered and asserted the cycle after cnt=0 with idx=0, aligned with the first output cycle of the slot.
- DIGITS=1: idx stays 0; a transfer happens at every slot wrap.
- Reset mid-frame: immediate dark outputs; scanning restarts at digit 0 and a pending load is discarded.

Test Plan (DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, both polarities active-low):
- Reset, then idle -> an=4'b1111 and seg=7'h7F. First frame_start occurs 1 cycle after reset release. an sequence per slot is 2 cycles 1111 then 6 cycles 1110; next slots select 1101, 1011, 0111; period 32 cycles.
- load value=16'h12AF, dp=0, blank=0, lz_en=0 mid-frame -> the current frame still shows 0000. From the next frame_start: digit0 seg=~7'b1110001, digit1 ~7'b1110111, digit2 ~7'b1011011, digit3 ~7'b0000110.
- load value=16'h0040, lz_en=1 -> digits 3 and 2 dark (seg=7'h7F, an still cycles). Digit1 shows 4 (~7'b1100110); digit0 shows 0 (~7'b0111111). value=16'h0000 with lz_en=1 -> only digit0 lit, showing 0.
- dp=4'b0100, blank=4'b0001 -> seg_dp=0 only during digit2's lit cycles. Digit0 is fully dark, including seg_dp.
- Two loads (16'h1111 then 16'h2222) within one frame, plus a third load (16'h3333) on the boundary cycle -> the next frame shows 3333. 1111 and 2222 never appear, and no digits change mid-frame.
- Assert rst during digit2's lit phase -> outputs dark in the same cycle (async). After release, scanning resumes at digit0 with value 0000, and a pre-reset pending load never appears.
